// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: FSM states and the queued store entry.
package store_buffer_pkg;

    // One downstream cache transaction at a time; loads and stores share WAIT_HI/WAIT_LO.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE_RD,
        ISSUE_WR,
        WAIT_HI,
        WAIT_LO,
        DONE_RD
    } sb_state_e;

    // Queued store: byte address, store data, cache sign_mask ([3]=sign, [2]=word, [1]=half, [0]=byte).
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Store queue: DEPTH entries, head/full/empty, and a parallel word-address match
// against every valid entry (including the head while it is being written out).
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  sb_entry_t       push_entry,
    input  logic            pop,
    input  logic [29:0]     match_word,
    output sb_entry_t       head,
    output logic            full,
    output logic            empty,
    output logic            hit
);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] offset;

    // Entry storage written at the tail.
    // NOTE: the array has no reset; an entry is only ever observed when count_q says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Word-address match across all valid entries, head included.
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (({1'b0, offset} < count_q) && (entries[i].addr[31:2] == match_word)) begin
                hit = 1'b1;
            end
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the CPU memory stage and the cache port. Stores retire
// into a queue; loads take priority unless they hit a queued word, which drains first.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_stall
);

    sb_state_e state;
    sb_state_e state_nxt;
    logic      op_rd_q;     // transaction in flight is a load
    logic      skip_rd_q;   // cycle after DONE_RD: the CPU may still show the finished load
    logic      load_pend;
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;
    logic      hit;
    sb_entry_t push_entry;
    sb_entry_t head;

    assign load_pend  = cpu_memread && !skip_rd_q;
    assign push       = cpu_memwrite && !full;
    assign pop        = (state == WAIT_LO) && !mem_stall && !op_rd_q;
    assign push_entry = '{addr: cpu_addr, data: cpu_write_data, mask: cpu_sign_mask};

    // Full is the registered count, so a store arriving at full stalls even during a pop.
    assign cpu_stall = !reset && ((cpu_memwrite && full) ||
                                  (load_pend && (state != DONE_RD)));

    store_buffer_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .match_word (cpu_addr[31:2]),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .hit        (hit)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a non-matching load wins over queued stores; a matching load waits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_pend && !hit) state_nxt = ISSUE_RD;
                else if (!empty)       state_nxt = ISSUE_WR;
            end
            ISSUE_RD, ISSUE_WR: state_nxt = WAIT_HI;
            WAIT_HI:  if (mem_stall)  state_nxt = WAIT_LO;
            WAIT_LO:  if (!mem_stall) state_nxt = op_rd_q ? DONE_RD : IDLE;
            DONE_RD:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Registered cache request, load result capture and the post-load skip flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_rd_q        <= 1'b0;
            skip_rd_q      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_sign_mask  <= '0;
            cpu_read_data  <= '0;
        end else begin
            skip_rd_q    <= (state == DONE_RD);
            mem_memread  <= (state_nxt == ISSUE_RD);
            mem_memwrite <= (state_nxt == ISSUE_WR);
            if (state_nxt == ISSUE_RD) begin
                op_rd_q       <= 1'b1;
                mem_addr      <= cpu_addr;
                mem_sign_mask <= cpu_sign_mask;
            end else if (state_nxt == ISSUE_WR) begin
                op_rd_q        <= 1'b0;
                mem_addr       <= head.addr;
                mem_write_data <= head.data;
                mem_sign_mask  <= head.mask;
            end
            // Captured on the edge into DONE_RD so it is valid while cpu_stall is low.
            if ((state == WAIT_LO) && !mem_stall && op_rd_q) begin
                cpu_read_data <= mem_read_data;
            end
        end
    end

endmodule
